// File: rtl/sound_pkg.sv
// Shared definitions for the sound frame sequencer and its channel status logic.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sound_pkg;

    localparam int NUM_CHANNELS = 4;

    localparam int CH_SQ1   = 0;
    localparam int CH_SQ2   = 1;
    localparam int CH_WAVE  = 2;
    localparam int CH_NOISE = 3;

    // 4.194304 MHz system clock / 512 Hz frame-sequencer rate
    localparam int DEFAULT_CLK_DIV = 8192;

    typedef logic [2:0] seq_step_t;

    localparam seq_step_t SWEEP_STEP_A = 3'd2;
    localparam seq_step_t SWEEP_STEP_B = 3'd6;
    localparam seq_step_t ENV_STEP     = 3'd7;

endpackage

// File: rtl/frame_prescaler.sv
// Divides system_clock down to the frame-sequencer step rate; emits a wrap pulse every CLK_DIV enabled cycles.
// Latency: wrap is combinational from the counter state (high during the last count of each period).
// Backpressure: none; clear holds the counter at zero and suppresses wrap.
module frame_prescaler #(
    parameter int CLK_DIV = 8192,
    parameter int PRESC_W = $clog2(CLK_DIV)
) (
    input  logic system_clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam logic [PRESC_W-1:0] LAST_COUNT = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] count_q;

    // Wrap fires on the final count of each period, only while counting is enabled
    always_comb begin
        wrap = enable && !clear && (count_q == LAST_COUNT);
    end

    // Free-running modulo-CLK_DIV counter with synchronous clear
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            if (wrap) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/sound_frame_sequencer.sv
// Frame sequencer: 512 Hz step generator issuing length/sweep/envelope strobes, plus NR52 channel on/off status.
// Latency: strobes one cycle after prescaler wrap; channel_restart and channel_on update one cycle after the event.
// Backpressure: none, all outputs are fire-and-forget. Define SOUND_SWEEP_OVERFLOW_EN to add the sweep_overflow input.
module sound_frame_sequencer
    import sound_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int PRESC_W = $clog2(CLK_DIV)
) (
    input  logic                    system_clock,
    input  logic                    reset,
    input  logic                    master_enable,
    input  logic [NUM_CHANNELS-1:0] trigger,
    input  logic [NUM_CHANNELS-1:0] dac_enable,
    input  logic [NUM_CHANNELS-1:0] length_expire,
`ifdef SOUND_SWEEP_OVERFLOW_EN
    input  logic                    sweep_overflow,
`endif
    output logic                    length_tick,
    output logic                    sweep_tick,
    output logic                    envelope_tick,
    output logic [NUM_CHANNELS-1:0] channel_restart,
    output logic [NUM_CHANNELS-1:0] channel_on
);

    logic                    step_wrap;
    seq_step_t               step_q;
    logic [NUM_CHANNELS-1:0] off_event;

    frame_prescaler #(
        .CLK_DIV (CLK_DIV),
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .system_clock (system_clock),
        .reset        (reset),
        .enable       (master_enable),
        .clear        (!master_enable),
        .wrap         (step_wrap)
    );

    // Low-priority switch-off events: length expiry, plus square1 sweep overflow when enabled
    always_comb begin
        off_event = length_expire;
`ifdef SOUND_SWEEP_OVERFLOW_EN
        off_event[CH_SQ1] = length_expire[CH_SQ1] | sweep_overflow;
`endif
    end

    // Step counter and tick strobes decoded from the step being left on each wrap
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            step_q        <= '0;
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end else if (!master_enable) begin
            step_q        <= '0;
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end else if (step_wrap) begin
            step_q        <= step_q + 3'd1;
            length_tick   <= ~step_q[0];
            sweep_tick    <= (step_q == SWEEP_STEP_A) || (step_q == SWEEP_STEP_B);
            envelope_tick <= (step_q == ENV_STEP);
        end else begin
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end
    end

    // Restart pulse mirrors each trigger one cycle later; DAC state does not suppress it
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            channel_restart <= '0;
        end else if (!master_enable) begin
            channel_restart <= '0;
        end else begin
            channel_restart <= trigger;
        end
    end

    // Per-channel status: power-off beats trigger, trigger beats expiry, otherwise hold
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            channel_on <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (!master_enable || !dac_enable[i]) begin
                    channel_on[i] <= 1'b0;
                end else if (trigger[i]) begin
                    channel_on[i] <= 1'b1;
                end else if (off_event[i]) begin
                    channel_on[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed bench for sound_frame_sequencer with CLK_DIV=4 and a scoreboard of expected outputs.
// Latency: expectations are popped one clock after the stimulus that produced them.
// Backpressure: n/a.
module tb_sound_frame_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       master = 1'b0;
    logic [3:0] trig = '0;
    logic [3:0] dac = '0;
    logic [3:0] lexp = '0;
    logic       sov = 1'b0;

    logic       length_tick;
    logic       sweep_tick;
    logic       envelope_tick;
    logic [3:0] channel_restart;
    logic [3:0] channel_on;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [2:0] ticks;
    } tick_exp_t;

    typedef struct {
        string      tag;
        logic [3:0] restart;
        logic [3:0] on;
    } ch_exp_t;

    tick_exp_t tick_q[$];
    ch_exp_t   ch_q[$];

    sound_frame_sequencer #(.CLK_DIV(DIV)) dut (
        .system_clock    (clk),
        .reset           (rst_n),
        .master_enable   (master),
        .trigger         (trig),
        .dac_enable      (dac),
        .length_expire   (lexp),
`ifdef SOUND_SWEEP_OVERFLOW_EN
        .sweep_overflow  (sov),
`endif
        .length_tick     (length_tick),
        .sweep_tick      (sweep_tick),
        .envelope_tick   (envelope_tick),
        .channel_restart (channel_restart),
        .channel_on      (channel_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Expected ticks for edge n counted from the first enabled edge
    function automatic logic [2:0] model_ticks(input int n);
        int out_step;
        logic [2:0] t;
        t = 3'b000;
        if (n % DIV == 0) begin
            out_step = (n / DIV - 1) % 8;
            t[2] = (out_step % 2 == 0);
            t[1] = (out_step == 2) || (out_step == 6);
            t[0] = (out_step == 7);
        end
        return t;
    endfunction

    task automatic pop_tick();
        tick_exp_t e;
        e = tick_q.pop_front();
        chk(e.tag, {13'd0, length_tick, sweep_tick, envelope_tick}, {13'd0, e.ticks});
    endtask

    // Drive channel stimulus for one cycle, then compare against the queued expectation
    task automatic ch_step(input string tag, input logic [3:0] t, input logic [3:0] le,
                           input logic s, input logic [3:0] exp_rs, input logic [3:0] exp_on);
        ch_exp_t e;
        trig = t;
        lexp = le;
        sov  = s;
        ch_q.push_back('{tag, exp_rs, exp_on});
        step_clk();
        trig = '0;
        lexp = '0;
        sov  = 1'b0;
        e = ch_q.pop_front();
        chk({e.tag, "_restart"}, {12'd0, channel_restart}, {12'd0, e.restart});
        chk({e.tag, "_on"}, {12'd0, channel_on}, {12'd0, e.on});
    endtask

    initial begin
        // Reset state
        repeat (3) step_clk();
        chk("reset_state", {9'd0, length_tick, sweep_tick, envelope_tick, channel_restart},
            16'd0);
        chk("reset_on", {12'd0, channel_on}, 16'd0);

        // Tick schedule from reset release with master enabled
        master = 1'b1;
        rst_n  = 1'b1;
        for (int n = 1; n <= 64; n++) tick_q.push_back('{$sformatf("tick_e%0d", n), model_ticks(n)});
        for (int n = 1; n <= 64; n++) begin
            step_clk();
            pop_tick();
        end

        // Channel status
        dac = 4'hF;
        ch_step("trig_0101", 4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0101);
        ch_step("expire_0", 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0100);
        ch_step("trig_vs_expire_1", 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0110);
        ch_step("restart_width", 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0110);
        ch_step("b2b_a", 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0110);
        ch_step("b2b_b", 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0110);
        ch_step("b2b_end", 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0110);
        dac = 4'b1011;
        ch_step("dac_off_trig_2", 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0010);
        ch_step("trig_noise", 4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b1010);
        dac = 4'b0011;
        ch_step("dac_off_noise", 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010);
        dac = 4'hF;

        // Resynchronise the step counter via master off/on, then drop master mid step 5
        master = 1'b0;
        step_clk();
        chk("master_off_on", {12'd0, channel_on}, 16'd0);
        master = 1'b1;
        ch_step("retrig_after_on", 4'b0011, 4'b0000, 1'b0, 4'b0011, 4'b0011);
        repeat (21) step_clk();
        master = 1'b0;
        ch_step("off_ignores_trig", 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        for (int n = 0; n < 10; n++) tick_q.push_back('{$sformatf("off_tick%0d", n), 3'b000});
        for (int n = 0; n < 10; n++) begin
            step_clk();
            pop_tick();
        end
        master = 1'b1;
        for (int n = 1; n <= 12; n++) tick_q.push_back('{$sformatf("reen_e%0d", n), model_ticks(n)});
        for (int n = 1; n <= 12; n++) begin
            step_clk();
            pop_tick();
        end

`ifdef SOUND_SWEEP_OVERFLOW_EN
        ch_step("ovf_trig", 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001);
        ch_step("ovf_clear", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        ch_step("ovf_vs_trig", 4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001);
`endif

        // Asynchronous reset mid-count with a restart pulse pending on the outputs
        ch_step("pre_reset_trig", 4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", {9'd0, length_tick, sweep_tick, envelope_tick, channel_restart},
            16'd0);
        chk("async_reset_on", {12'd0, channel_on}, 16'd0);
        step_clk();
        chk("reset_held_on", {12'd0, channel_on}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_frame_sequencer.md
Name: sound_frame_sequencer

Overview:
- Central controller for the four sound channels (square1, square2, wave, noise).
- Generates the 512 Hz frame-sequencer step from system_clock and issues one-cycle length, sweep and envelope tick strobes.
- Replaces the per-channel clock dividers.
- Owns channel on/off status (NR52 bits 3:0): channels are enabled on trigger and disabled on length expiry, DAC-off or master-off.

Parameters:
- CLK_DIV, 8192, system_clock cycles per frame-sequencer step (4.194304 MHz / 512); must be >= 2.
- PRESC_W, $clog2(CLK_DIV), prescaler counter width.

Ports:
- system_clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- master_enable  input  1  NR52 bit 7 (sound master on).
- trigger  input  4  one-cycle pulse per channel on NRx4 bit-7 write; index 0=sq1, 1=sq2, 2=wave, 3=noise.
- dac_enable  input  4  per-channel DAC power (NRx2[7:3]!=0; NR30 bit 7 for wave).
- length_expire  input  4  one-cycle pulse from the channel's length counter reaching zero with length enable set.
- length_tick  output  1  256 Hz strobe.
- sweep_tick  output  1  128 Hz strobe (square1 only).
- envelope_tick  output  1  64 Hz strobe.
- channel_restart  output  4  one-cycle restart pulse to the channel datapath.
- channel_on  output  4  NR52 status bits 3:0.

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, step=0, all outputs 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while master_enable=1.
  - Wrap event W is asserted when prescaler==CLK_DIV-1 and master_enable=1; on W the prescaler returns to 0.
- Step counter (3 bits):
  - On W: step <= step+1, with natural wrap 7->0.
  - Ticks are registered from the outgoing step value, so each is high exactly the cycle after W:
    - length_tick = (step[0]==0), i.e. steps 0,2,4,6.
    - sweep_tick = (step==2 || step==6).
    - envelope_tick = (step==7).
  - Ticks are otherwise 0; each tick is never high for 2 consecutive cycles.
- Tick timing: first length_tick occurs CLK_DIV+1 cycles after master_enable rises. Period is 2*CLK_DIV for length, 4*CLK_DIV for sweep, 8*CLK_DIV for envelope.
- master_enable=0:
  - Prescaler and step are held at 0 synchronously.
  - Ticks, channel_on and channel_restart are forced to 0; trigger is ignored.
  - When master_enable returns to 1, counting restarts from step 0, prescaler 0.
- Channel status, per channel i, evaluated in priority order:
  1. master_enable=0 or dac_enable[i]=0: channel_on[i] <= 0.
  2. trigger[i]: channel_on[i] <= 1 and channel_restart[i] <= 1 in the next cycle.
  3. length_expire[i]: channel_on[i] <= 0.
  4. Otherwise hold.
- Simultaneous events:
  - trigger and length_expire in the same cycle: trigger wins, channel stays on.
  - trigger with dac_enable=0: channel_restart still pulses, channel_on stays 0.
- channel_restart latency is 1 cycle, width is 1 cycle per trigger pulse. Back-to-back triggers give back-to-back restart pulses.
- Ticks are independent of channel_on; the channels gate the ticks themselves.
- Reset asserted mid-operation clears everything immediately, with no pending pulse delivered.

Optional Feature:
- Macro: SOUND_SWEEP_OVERFLOW_EN.
- When defined:
  - Adds input sweep_overflow (1 bit, one-cycle pulse from square1 frequency sweep when the computed frequency exceeds 2047).
  - sweep_overflow clears channel_on[0] at priority level 3, alongside length_expire. Trigger still wins.
- When undefined: the port is absent and channel_on[0] clears only via length_expire, DAC-off or master-off.

Decomposition:
- Shared package sound_pkg holds:
  - Channel index constants CH_SQ1=0, CH_SQ2=1, CH_WAVE=2, CH_NOISE=3.
  - NUM_CHANNELS=4.
  - typedef seq_step_t (3 bits).
  - Step constants SWEEP_STEP_A=2, SWEEP_STEP_B=6, ENV_STEP=7.
  - Default CLK_DIV.
- One sub-module, frame_prescaler: parameterised counter with enable and synchronous clear that outputs the wrap pulse W. Step decode and channel status live in the top.

Test Plan:
- CLK_DIV=4, master_enable=1 from reset release, run 64 cycles:
  - length_tick at cycles 5,13,21,29,…; sweep_tick at 13 and 29; envelope_tick at 33.
  - All strobes exactly 1 cycle wide.
- dac_enable=4'hF, trigger=4'b0101 pulse:
  - Next cycle channel_restart=4'b0101 and channel_on=4'b0101.
  - Then length_expire=4'b0001 -> channel_on=4'b0100.
- trigger[1] and length_expire[1] in the same cycle -> channel_on[1]=1, channel_restart[1]=1.
- dac_enable[2]=0 with trigger[2] -> channel_restart[2]=1, channel_on[2]=0. Later dropping dac_enable[3] clears an on noise channel.
- Drop master_enable mid-step-5:
  - channel_on=0 and no ticks; triggers ignored while off.
  - Re-enable -> first length_tick CLK_DIV+1 cycles later (step 0 restart).
- With SOUND_SWEEP_OVERFLOW_EN: sweep_overflow pulse clears channel_on[0]. The same pulse coincident with trigger[0] keeps it on.
- Assert reset mid-count -> all outputs 0 immediately, before the next clock edge.
